easyaxi_slv_wr_ctrl: RTL and testbench
======================================

// Module: easyaxi_slv_wr_ctrl
// PURPOSE
//  AXI slave write-side controller. Sits downstream of the master write controller on the AW/W/B link.
//  Queues AW requests in order and consumes W beats against the oldest request.
//  Generates per-beat FIXED/INCR/WRAP addresses onto a zero-latency memory write port.
//  Returns one in-order B response per burst.
// PARAMETERS
//  OST_DEPTH      16      AW queue and B queue depth (power of 2, >=2)
//  SLV_ADDR_BASE  'h0     decode window base (used only with EASYAXI_SLV_WR_DECERR_EN)
//  SLV_ADDR_SIZE  'h1000  decode window size in bytes (EASYAXI_SLV_WR_DECERR_EN only)
// PORTS
//  clk              in   1              clock, single domain
//  rst_n            in   1              asynchronous active-low reset
//  axi_slv_awvalid  in   1              AW valid
//  axi_slv_awready  out  1              AW ready
//  axi_slv_awid/addr/len/size/burst/user in `AXI_*_W  AW payload
//  axi_slv_wvalid   in   1              W valid
//  axi_slv_wready   out  1              W ready
//  axi_slv_wdata    in   `AXI_DATA_W    write data
//  axi_slv_wstrb    in   `AXI_DATA_W/8  byte strobes
//  axi_slv_wlast    in   1              last beat marker from master
//  axi_slv_bvalid   out  1              B valid
//  axi_slv_bready   in   1              B ready
//  axi_slv_bid/bresp/buser out `AXI_ID_W/`AXI_RESP_W/`AXI_USER_W  B payload
//  mem_wen          out  1              memory write strobe, one per accepted beat
//  mem_addr         out  `AXI_ADDR_W    beat byte address
//  mem_wdata/wstrb  out  `AXI_DATA_W/`AXI_DATA_W/8  pass-through of wdata/wstrb
// BEHAVIOUR
//  Reset values: awready=1, wready=0, bvalid=0, mem_wen=0; bid/bresp/buser=0; queues empty; counters 0.
//  AW: awready = ~aw_full. Push on awvalid&awready. Push and pop in the same cycle are legal when full.
//  W: wready = ~aw_empty & ~b_full. Beats always apply to the head AW entry.
//   mem_wen = wvalid&wready, combinational, 0 latency. mem_addr = current beat address.
//  Beat address: beat0 = awaddr. FIXED: constant. INCR: += (1<<size).
//   WRAP: bound = addr & ~((len+1)<<size)-1. Next address wraps to bound when it reaches bound+((len+1)<<size).
//  Beat counter (8 bit): counts 0..awlen. The burst ends on beat with cnt==awlen, regardless of wlast.
//   wlast!=(cnt==awlen) on any beat -> burst resp sticks SLVERR.
//  Resp accumulation: max severity over burst (OKAY<SLVERR<DECERR).
//  Burst end: pop AW head, push {awid, resp, awuser} to B queue, reset cnt/resp. bvalid rises next cycle.
//  B: bvalid = ~b_empty. Pop on bvalid&bready. bid order == AW acceptance order.
//  b_full with a burst mid-flight: wready=0 until a B pop. B push never overflows.
//  Reset mid-operation: all queued AW/B entries and the partial burst are discarded. Outputs return to reset values.
// CONFIGURATION
//  EASYAXI_SLV_WR_DECERR_EN defined: AW outside [SLV_ADDR_BASE, BASE+SIZE) is flagged at push.
//   Its W beats are accepted with mem_wen=0, and its bresp=DECERR.
//  Not defined: no decode; every burst writes memory; DECERR is never returned.
// STRUCTURE
//  Shared include easyaxi_define.v: `AXI_*_W widths, `AXI_BURST_FIXED/INCR/WRAP, `AXI_RESP_OKAY/SLVERR/DECERR.
//  Sub-module easyaxi_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/head), instanced for the AW and B queues.
//  Beat address generator is local combinational logic.
// TESTING
//  INCR id=1 addr=0x10 len=3 size=4B, 4 beats -> mem_addr 0x10,0x14,0x18,0x1C; bid=1 bresp=OKAY 1 cycle after beat 4.
//  WRAP addr=0x34 len=3 size=4B -> mem_addr 0x34,0x38,0x3C,0x30; FIXED addr=0x30 len=3 -> 0x30 x4.
//  16 AWs with wvalid=0 -> awready=0 after 16th, 17th stalls. Then 64 beats -> 16 B in id order 0..15.
//  len=3 with wlast on beat 2 -> 4 writes still done, bresp=SLVERR. Next burst bresp=OKAY.
//  bready=0 until B full -> wready=0 mid-burst. One B pop -> wready=1 next cycle, no beat lost.
//  rst_n low mid-burst -> bvalid=0, wready=0, awready=1. With EASYAXI_SLV_WR_DECERR_EN: addr 0x2000 -> mem_wen=0, bresp=DECERR.

Source files
------------

// File: rtl/easyaxi_slv_wr_ctrl_pkg.sv
// Shared types, widths and helpers for the AXI slave write controller.
package easyaxi_slv_wr_ctrl_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_SIZE_W = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_USER_W = 4;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_RESP_W = 2;

  typedef enum logic [AXI_BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  // Encodings chosen so numeric order equals severity order.
  typedef enum logic [AXI_RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_SIZE_W-1:0] size;
    burst_e                burst;
    logic [AXI_USER_W-1:0] user;
    logic                  dec;
  } aw_entry_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    resp_e                 resp;
    logic [AXI_USER_W-1:0] user;
  } b_entry_t;

  function automatic resp_e resp_max(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

  // Address of the beat following 'cur'; 'base' is the burst start address.
  function automatic logic [AXI_ADDR_W-1:0] beat_next_addr(
    input logic [AXI_ADDR_W-1:0] cur,
    input logic [AXI_ADDR_W-1:0] base,
    input logic [AXI_LEN_W-1:0]  len,
    input logic [AXI_SIZE_W-1:0] size,
    input burst_e                burst
  );
    logic [AXI_ADDR_W-1:0] incr;
    logic [AXI_ADDR_W-1:0] total;
    logic [AXI_ADDR_W-1:0] bound;
    logic [AXI_ADDR_W-1:0] nxt;
    incr  = AXI_ADDR_W'(1) << size;
    total = (AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size;
    bound = base & ~(total - AXI_ADDR_W'(1));
    nxt   = cur + incr;
    case (burst)
      BURST_FIXED: nxt = cur;
      BURST_WRAP:  if (nxt == bound + total) nxt = bound;
      default:     ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Single-clock FIFO with registered head; push while full is allowed when popping.
module easyaxi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/easyaxi_slv_wr_ctrl.sv
// AXI slave write controller: in-order AW queue, per-beat address generation
// onto a zero-latency memory write port, in-order B queue.
// Optional address decode with DECERR: define EASYAXI_SLV_WR_DECERR_EN.
module easyaxi_slv_wr_ctrl
  import easyaxi_slv_wr_ctrl_pkg::*;
#(
  parameter int unsigned           OST_DEPTH     = 16,
  parameter logic [AXI_ADDR_W-1:0] SLV_ADDR_BASE = '0,
  parameter logic [AXI_ADDR_W-1:0] SLV_ADDR_SIZE = 32'h1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    axi_slv_awvalid,
  output logic                    axi_slv_awready,
  input  logic [AXI_ID_W-1:0]     axi_slv_awid,
  input  logic [AXI_ADDR_W-1:0]   axi_slv_awaddr,
  input  logic [AXI_LEN_W-1:0]    axi_slv_awlen,
  input  logic [AXI_SIZE_W-1:0]   axi_slv_awsize,
  input  logic [AXI_BURST_W-1:0]  axi_slv_awburst,
  input  logic [AXI_USER_W-1:0]   axi_slv_awuser,
  input  logic                    axi_slv_wvalid,
  output logic                    axi_slv_wready,
  input  logic [AXI_DATA_W-1:0]   axi_slv_wdata,
  input  logic [AXI_DATA_W/8-1:0] axi_slv_wstrb,
  input  logic                    axi_slv_wlast,
  output logic                    axi_slv_bvalid,
  input  logic                    axi_slv_bready,
  output logic [AXI_ID_W-1:0]     axi_slv_bid,
  output logic [AXI_RESP_W-1:0]   axi_slv_bresp,
  output logic [AXI_USER_W-1:0]   axi_slv_buser,
  output logic                    mem_wen,
  output logic [AXI_ADDR_W-1:0]   mem_addr,
  output logic [AXI_DATA_W-1:0]   mem_wdata,
  output logic [AXI_DATA_W/8-1:0] mem_wstrb
);

  localparam int unsigned AW_BITS = $bits(aw_entry_t);
  localparam int unsigned B_BITS  = $bits(b_entry_t);

  logic                  aw_full, aw_empty, aw_push, aw_pop, aw_dec;
  logic                  b_full, b_empty, b_push, b_pop;
  logic [AW_BITS-1:0]    aw_head_raw;
  logic [B_BITS-1:0]     b_head_raw;
  aw_entry_t             aw_in, aw_head;
  b_entry_t              b_in, b_head;

  logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;
  resp_e                 resp_q, resp_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;

  logic                  w_fire, last_beat;
  resp_e                 beat_resp, burst_resp;
  logic [AXI_ADDR_W-1:0] cur_addr;

`ifdef EASYAXI_SLV_WR_DECERR_EN
  localparam logic [AXI_ADDR_W:0] DEC_LO = {1'b0, SLV_ADDR_BASE};
  localparam logic [AXI_ADDR_W:0] DEC_HI = {1'b0, SLV_ADDR_BASE} + {1'b0, SLV_ADDR_SIZE};
  assign aw_dec = ({1'b0, axi_slv_awaddr} < DEC_LO) || ({1'b0, axi_slv_awaddr} >= DEC_HI);
`else
  logic unused_dec_params;
  assign aw_dec            = 1'b0;
  assign unused_dec_params = ^{SLV_ADDR_BASE, SLV_ADDR_SIZE};
`endif

  assign axi_slv_awready = ~aw_full;
  assign aw_push         = axi_slv_awvalid & ~aw_full;
  assign aw_head         = aw_entry_t'(aw_head_raw);

  // Pack the accepted AW request, with its decode result, for the AW queue.
  always_comb begin
    aw_in       = '0;
    aw_in.id    = axi_slv_awid;
    aw_in.addr  = axi_slv_awaddr;
    aw_in.len   = axi_slv_awlen;
    aw_in.size  = axi_slv_awsize;
    aw_in.burst = burst_e'(axi_slv_awburst);
    aw_in.user  = axi_slv_awuser;
    aw_in.dec   = aw_dec;
  end

  easyaxi_sync_fifo #(.WIDTH(AW_BITS), .DEPTH(OST_DEPTH)) u_aw_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (aw_push),
    .push_data (aw_in),
    .pop       (aw_pop),
    .full      (aw_full),
    .empty     (aw_empty),
    .head      (aw_head_raw)
  );

  // Beats are stalled while B is full so a burst end can never overflow B.
  assign axi_slv_wready = ~aw_empty & ~b_full;
  assign w_fire         = axi_slv_wvalid & axi_slv_wready;
  assign last_beat      = (cnt_q == aw_head.len);
  assign cur_addr       = (cnt_q == '0) ? aw_head.addr : addr_q;
  assign aw_pop         = w_fire & last_beat;
  assign b_push         = aw_pop;

  assign mem_wen   = w_fire & ~aw_head.dec;
  assign mem_addr  = cur_addr;
  assign mem_wdata = axi_slv_wdata;
  assign mem_wstrb = axi_slv_wstrb;

  // Beat sequencing: counter, running response, next beat address.
  always_comb begin
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    addr_d     = addr_q;
    beat_resp  = (axi_slv_wlast != last_beat) ? RESP_SLVERR : RESP_OKAY;
    if (aw_head.dec) beat_resp = RESP_DECERR;
    burst_resp = resp_max(resp_q, beat_resp);
    b_in       = '0;
    b_in.id    = aw_head.id;
    b_in.resp  = burst_resp;
    b_in.user  = aw_head.user;
    if (w_fire) begin
      if (last_beat) begin
        cnt_d  = '0;
        resp_d = RESP_OKAY;
        addr_d = '0;
      end else begin
        cnt_d  = cnt_q + 8'd1;
        resp_d = burst_resp;
        addr_d = beat_next_addr(cur_addr, aw_head.addr, aw_head.len,
                                aw_head.size, aw_head.burst);
      end
    end
  end

  // Burst progress registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      resp_q <= RESP_OKAY;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      resp_q <= resp_d;
      addr_q <= addr_d;
    end
  end

  easyaxi_sync_fifo #(.WIDTH(B_BITS), .DEPTH(OST_DEPTH)) u_b_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (b_push),
    .push_data (b_in),
    .pop       (b_pop),
    .full      (b_full),
    .empty     (b_empty),
    .head      (b_head_raw)
  );

  assign b_head         = b_entry_t'(b_head_raw);
  assign axi_slv_bvalid = ~b_empty;
  assign b_pop          = ~b_empty & axi_slv_bready;
  // Payload forced to zero while idle so stale queue contents never show.
  assign axi_slv_bid    = b_empty ? '0 : b_head.id;
  assign axi_slv_bresp  = b_empty ? '0 : b_head.resp;
  assign axi_slv_buser  = b_empty ? '0 : b_head.user;

endmodule

// File: tb/tb_easyaxi_slv_wr_ctrl.sv
// Self-checking bench for easyaxi_slv_wr_ctrl (scoreboard of memory writes and B responses).
module tb_easyaxi_slv_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic [3:0]  awuser = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b1;
  logic [3:0]  bid, buser;
  logic [1:0]  bresp;
  logic        mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q [$];
  logic [35:0] exp_data_q [$];
  logic [9:0]  exp_b_q [$];

  always #5 clk = ~clk;

  easyaxi_slv_wr_ctrl #(.OST_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_slv_awvalid(awvalid), .axi_slv_awready(awready),
    .axi_slv_awid(awid), .axi_slv_awaddr(awaddr), .axi_slv_awlen(awlen),
    .axi_slv_awsize(awsize), .axi_slv_awburst(awburst), .axi_slv_awuser(awuser),
    .axi_slv_wvalid(wvalid), .axi_slv_wready(wready), .axi_slv_wdata(wdata),
    .axi_slv_wstrb(wstrb), .axi_slv_wlast(wlast),
    .axi_slv_bvalid(bvalid), .axi_slv_bready(bready), .axi_slv_bid(bid),
    .axi_slv_bresp(bresp), .axi_slv_buser(buser),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  // Reference beat address: wrap computed as an offset modulo the wrap span.
  function automatic logic [31:0] ref_addr(input logic [31:0] a, input int unsigned len,
                                           input int unsigned size, input logic [1:0] burst,
                                           input int unsigned k);
    int unsigned incr, total, lo;
    incr  = 1 << size;
    total = (len + 1) * incr;
    case (burst)
      2'b00:   return a;
      2'b10: begin
        lo = (a / total) * total;
        return lo + ((a - lo + k * incr) % total);
      end
      default: return a + k * incr;
    endcase
  endfunction

  // Scoreboard: compare every memory write and every B handshake as it happens.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wen) begin
        checks++;
        if (exp_addr_q.size() == 0 || exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL mem_write_unexpected: addr=%h data=%h", mem_addr, mem_wdata);
        end else begin
          logic [31:0] ea;
          logic [35:0] ed;
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          if ({mem_addr, mem_wdata, mem_wstrb} !== {ea, ed}) begin
            errors++;
            $display("FAIL mem_write: got addr=%h data=%h strb=%h, want addr=%h data=%h strb=%h",
                     mem_addr, mem_wdata, mem_wstrb, ea, ed[35:4], ed[3:0]);
          end
        end
      end
      if (bvalid && bready) begin
        checks++;
        if (exp_b_q.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: bid=%0d bresp=%0d", bid, bresp);
        end else begin
          logic [9:0] eb;
          eb = exp_b_q.pop_front();
          if ({bid, bresp, buser} !== eb) begin
            errors++;
            $display("FAIL b_resp: got id=%0d resp=%0d user=%0d, want id=%0d resp=%0d user=%0d",
                     bid, bresp, buser, eb[9:6], eb[5:4], eb[3:0]);
          end
        end
      end
    end
  end

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [1:0] resp, input bit wr);
    int n;
    awvalid = 1'b1; awid = id; awaddr = a; awlen = len;
    awsize = size; awburst = burst; awuser = id ^ 4'h5;
    if (wr)
      for (int unsigned k = 0; k <= int'(len); k++)
        exp_addr_q.push_back(ref_addr(a, len, size, burst, k));
    exp_b_q.push_back({id, resp, id ^ 4'h5});
    n = 0;
    @(negedge clk);
    while (!awready && n < 300) begin @(negedge clk); n++; end
    if (!awready) begin
      errors++; checks++;
      $display("FAIL aw_timeout: awready=%b want 1", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last, input bit wr);
    int n;
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
    if (wr) exp_data_q.push_back({d, s});
    n = 0;
    @(negedge clk);
    while (!wready && n < 300) begin @(negedge clk); n++; end
    if (!wready) begin
      errors++; checks++;
      $display("FAIL w_timeout: wready=%b want 1", wready);
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({awready, wready, bvalid, mem_wen, bid, bresp, buser} !== {4'b1000, 10'b0}) begin
      errors++;
      $display("FAIL reset_in: got aw=%b w=%b b=%b wen=%b bid=%0d bresp=%0d buser=%0d want 1 0 0 0 0 0 0",
               awready, wready, bvalid, mem_wen, bid, bresp, buser);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, mem_wen} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_out: got aw=%b w=%b b=%b wen=%b want 1 0 0 0", awready, wready, bvalid, mem_wen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_incr;
    aw_send(4'd1, 32'h10, 8'd3, 3'd2, 2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0) begin
        errors++;
        $display("FAIL incr_bvalid_early: beat %0d bvalid=%b want 0", i, bvalid);
      end
      @(posedge clk); #1;
      w_beat(32'hA000_0000 + i, 4'hF, i == 3, 1'b1);
    end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || bid !== 4'd1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL incr_b_latency: bvalid=%b bid=%0d bresp=%0d want 1 1 0", bvalid, bid, bresp);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_wrap_fixed;
    aw_send(4'd2, 32'h34, 8'd3, 3'd2, 2'b10, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) w_beat(32'hB000_0000 + i, 4'h3, i == 3, 1'b1);
    aw_send(4'd3, 32'h30, 8'd3, 3'd2, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) w_beat(32'hC000_0000 + i, 4'hC, i == 3, 1'b1);
    // Larger wrap span from a non-aligned start inside the window.
    aw_send(4'd4, 32'h108, 8'd7, 3'd1, 2'b10, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) w_beat(32'hC100_0000 + i, 4'h1, i == 7, 1'b1);
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++)
      aw_send(4'(i), 32'h200 + 32'(i) * 32'h10, 8'd3, 3'd2, 2'b01, 2'b00, 1'b1);
    @(negedge clk);
    checks++;
    if (awready !== 1'b0) begin
      errors++;
      $display("FAIL aw_full_ready: awready=%b want 0", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b1; awid = 4'hF; awaddr = 32'h900;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (awready !== 1'b0) begin
        errors++;
        $display("FAIL aw_17th_stall: awready=%b want 0", awready);
      end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < 16; b++)
      for (int i = 0; i < 4; i++) w_beat(32'(b * 16 + i), 4'hF, i == 3, 1'b1);
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_wlast_err;
    aw_send(4'd7, 32'h40, 8'd3, 3'd2, 2'b01, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) w_beat(32'hD000_0000 + i, 4'hF, i == 2, 1'b1);
    aw_send(4'd8, 32'h60, 8'd1, 3'd2, 2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 2; i++) w_beat(32'hD100_0000 + i, 4'hF, i == 1, 1'b1);
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_b_backpressure;
    bready = 1'b0;
    for (int i = 0; i < 16; i++)
      aw_send(4'(i), 32'h400 + 32'(i) * 4, 8'd0, 3'd2, 2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 16; i++) w_beat(32'hE000_0000 + i, 4'hF, 1'b1, 1'b1);
    aw_send(4'd9, 32'h800, 8'd1, 3'd2, 2'b01, 2'b00, 1'b1);
    wvalid = 1'b1; wdata = 32'hF000_0001; wstrb = 4'hF; wlast = 1'b0;
    exp_data_q.push_back({32'hF000_0001, 4'hF});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wready !== 1'b0 || mem_wen !== 1'b0) begin
        errors++;
        $display("FAIL b_full_stall: wready=%b mem_wen=%b want 0 0", wready, mem_wen);
      end
    end
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    checks++;
    if (wready !== 1'b1 || mem_wen !== 1'b1) begin
      errors++;
      $display("FAIL b_pop_resume: wready=%b mem_wen=%b want 1 1", wready, mem_wen);
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    bready = 1'b1;
    w_beat(32'hF000_0002, 4'hF, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    aw_send(4'd5, 32'h500, 8'd3, 3'd2, 2'b01, 2'b00, 1'b1);
    w_beat(32'h1, 4'hF, 1'b0, 1'b1);
    w_beat(32'h2, 4'hF, 1'b0, 1'b1);
    wvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bvalid, wready, awready, mem_wen} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_mid: got b=%b w=%b aw=%b wen=%b want 0 0 1 0", bvalid, wready, awready, mem_wen);
    end
    wvalid = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete(); exp_b_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    // New burst must start from beat 0 with clean response state.
    aw_send(4'd6, 32'h600, 8'd1, 3'd2, 2'b01, 2'b00, 1'b1);
    w_beat(32'h11, 4'hF, 1'b0, 1'b1);
    w_beat(32'h12, 4'hF, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
  endtask

`ifdef EASYAXI_SLV_WR_DECERR_EN
  task automatic test_decerr;
    aw_send(4'd10, 32'h2000, 8'd1, 3'd2, 2'b01, 2'b11, 1'b0);
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; wdata = 32'(i); wstrb = 4'hF; wlast = (i == 1);
      @(negedge clk);
      checks++;
      if (wready !== 1'b1 || mem_wen !== 1'b0) begin
        errors++;
        $display("FAIL decerr_beat: wready=%b mem_wen=%b want 1 0", wready, mem_wen);
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    aw_send(4'd11, 32'h20, 8'd0, 3'd2, 2'b01, 2'b00, 1'b1);
    w_beat(32'h77, 4'hF, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
  endtask
`endif

  task automatic test_drain;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_addr_q.size() != 0 || exp_data_q.size() != 0 || exp_b_q.size() != 0 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending addr=%0d data=%0d b=%0d bvalid=%b want 0 0 0 0",
               exp_addr_q.size(), exp_data_q.size(), exp_b_q.size(), bvalid);
    end
  endtask

  initial begin
    test_reset;
    test_incr;
    test_wrap_fixed;
    test_back_to_back;
    test_wlast_err;
    test_b_backpressure;
    test_reset_mid;
`ifdef EASYAXI_SLV_WR_DECERR_EN
    test_decerr;
`endif
    test_drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
